// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access stage: req/gnt/rvalid bus master with alignment checks and load extension.
// Optional bus timeout watchdog enabled by defining MEM_ACCESS_BUS_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter bit BYTE_SWAP = 1'b1,
  parameter int TIMEOUT   = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_uns_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              exc_valid_o,
  output logic [4:0]        exc_code_o,
  output logic [ADDR_W-1:0] exc_badvaddr_o,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic              bus_we_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       rdata_q;
  logic              exc_q;
  logic [4:0]        exc_code_q;
  logic [ADDR_W-1:0] badvaddr_q;

  logic              misaligned;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic [31:0]       load_ext;
  logic              start_acc, start_exc, tmo_exc, capture;
  logic              tmo_hit;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Size 2'b11 is decoded as word everywhere via size[1].
  always_comb begin
    misaligned = (mem_size_i == 2'b01 && mem_addr_i[0]) ||
                 (mem_size_i[1] && (mem_addr_i[1:0] != 2'b00));
    be_calc    = 4'b1111;
    wdata_calc = BYTE_SWAP ? bswap(mem_wdata_i) : mem_wdata_i;
    if (mem_size_i == 2'b00) begin
      be_calc    = 4'b1000 >> mem_addr_i[1:0];
      wdata_calc = {4{mem_wdata_i[7:0]}};
    end else if (mem_size_i == 2'b01) begin
      be_calc    = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      wdata_calc = BYTE_SWAP ? {2{mem_wdata_i[7:0], mem_wdata_i[15:8]}}
                             : {2{mem_wdata_i[15:0]}};
    end
  end

  always_comb begin
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    r = BYTE_SWAP ? bswap(bus_rdata_i) : bus_rdata_i;
    case (addr_q[1:0])
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    h = addr_q[1] ? r[31:16] : r[15:0];
    load_ext = r;
    if (size_q == 2'b00)
      load_ext = uns_q ? {24'h0, b} : {{24{b[7]}}, b};
    else if (size_q == 2'b01)
      load_ext = uns_q ? {16'h0, h} : {{16{h[15]}}, h};
  end

`ifdef MEM_ACCESS_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n)
      tmo_cnt_q <= '0;
    else if (start_acc)
      tmo_cnt_q <= '0;
    else if (state_q == REQ || state_q == WAIT)
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end

  assign tmo_hit = (state_q == REQ || state_q == WAIT) &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    start_acc   = 1'b0;
    start_exc   = 1'b0;
    tmo_exc     = 1'b0;
    capture     = 1'b0;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    exc_valid_o = 1'b0;
    bus_req_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          if (misaligned) begin
            start_exc = 1'b1;
            stall_o   = 1'b1;
            state_d   = DONE;
          end else if (!flush_i) begin
            start_acc = 1'b1;
            stall_o   = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        stall_o   = 1'b1;
        bus_req_o = 1'b1;
        if (flush_i)
          state_d = bus_gnt_i ? DRAIN : IDLE;
        else if (bus_gnt_i)
          state_d = WAIT;
        else if (tmo_hit) begin
          tmo_exc = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (flush_i)
          state_d = bus_rvalid_i ? IDLE : DRAIN;
        else if (bus_rvalid_i) begin
          capture = !we_q;
          state_d = DONE;
        end else if (tmo_hit) begin
          tmo_exc = 1'b1;
          state_d = DONE;
        end
      end
      DRAIN: begin
        stall_o = 1'b1;
        if (bus_rvalid_i)
          state_d = IDLE;
      end
      DONE: begin
        done_o      = !exc_q && !flush_i;
        exc_valid_o = exc_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      addr_q     <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rdata_q    <= '0;
      exc_q      <= 1'b0;
      exc_code_q <= '0;
      badvaddr_q <= '0;
    end else begin
      if (start_acc) begin
        addr_q  <= mem_addr_i;
        be_q    <= be_calc;
        we_q    <= mem_we_i;
        wdata_q <= wdata_calc;
        size_q  <= mem_size_i;
        uns_q   <= mem_uns_i;
        exc_q   <= 1'b0;
      end
      if (start_exc) begin
        exc_q      <= 1'b1;
        exc_code_q <= mem_we_i ? 5'h05 : 5'h04;
        badvaddr_q <= mem_addr_i;
      end
      if (tmo_exc) begin
        exc_q      <= 1'b1;
        exc_code_q <= 5'h07;
        badvaddr_q <= addr_q;
      end
      if (capture)
        rdata_q <= load_ext;
    end
  end

  assign rdata_o        = rdata_q;
  assign exc_code_o     = exc_code_q;
  assign exc_badvaddr_o = badvaddr_q;
  assign bus_addr_o     = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_be_o       = be_q;
  assign bus_we_o       = we_q && (state_q == REQ);
  assign bus_wdata_o    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected responses, a negedge monitor pops them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_uns, flush;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall, done, exc_valid;
  logic [31:0] rdata;
  logic [4:0]  exc_code;
  logic [31:0] badvaddr;
  logic        bus_req, bus_gnt, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  typedef struct {
    logic        is_exc;
    logic [31:0] rdata;
    logic [4:0]  code;
    logic [31:0] badv;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .BYTE_SWAP(1'b1), .TIMEOUT(16)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size), .mem_uns_i(mem_uns),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .flush_i(flush),
    .stall_o(stall), .done_o(done), .rdata_o(rdata),
    .exc_valid_o(exc_valid), .exc_code_o(exc_code), .exc_badvaddr_o(badvaddr),
    .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_we_o(bus_we), .bus_wdata_o(bus_wdata), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (done === 1'b1 || exc_valid === 1'b1)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_response: got done=%0b exc=%0b expected none at %0t", done, exc_valid, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_kind", {30'h0, done, exc_valid}, e.is_exc ? 32'h1 : 32'h2);
        if (e.is_exc) begin
          check("exc_code", {27'h0, exc_code}, {27'h0, e.code});
          check("exc_badvaddr", badvaddr, e.badv);
        end else begin
          check("rdata", rdata, e.rdata);
        end
      end
    end
  end

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_lat, input int rv_lat, input logic [31:0] rsp,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input logic flush_done);
    exp_t e;
    if (!we) model_rdata = exp_rd;
    if (!flush_done) begin
      e.is_exc = 1'b0; e.rdata = model_rdata; e.code = '0; e.badv = '0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_size = size; mem_uns = uns; mem_addr = addr; mem_wdata = wdata;
    @(negedge clk);
    check("stall_idle_req", stall, 1);
    check("no_bus_req_idle", bus_req, 0);
    @(posedge clk); #1;
    mem_req = 1'b0;
    for (int i = 0; i <= gnt_lat; i++) begin
      bus_gnt = (i == gnt_lat);
      @(negedge clk);
      check("bus_req", bus_req, 1);
      check("stall_req", stall, 1);
      check("bus_addr", bus_addr, {addr[31:2], 2'b00});
      check("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
      check("bus_we", bus_we, we);
      if (we) check("bus_wdata", bus_wdata, exp_wd);
      @(posedge clk); #1;
    end
    bus_gnt = 1'b0;
    for (int i = 0; i <= rv_lat; i++) begin
      bus_rvalid = (i == rv_lat);
      bus_rdata  = rsp;
      @(negedge clk);
      check("bus_req_wait", bus_req, 0);
      check("stall_wait", stall, 1);
      @(posedge clk); #1;
    end
    bus_rvalid = 1'b0;
    flush = flush_done;
    @(negedge clk);
    check("stall_done", stall, 0);
    if (flush_done) begin
      check("done_suppressed", done, 0);
      check("rdata_after_flush", rdata, exp_rd);
    end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic misaligned(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [4:0] code);
    exp_t e;
    e.is_exc = 1'b1; e.rdata = '0; e.code = code; e.badv = addr;
    sb.push_back(e);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_size = size; mem_uns = 1'b0; mem_addr = addr; mem_wdata = '0;
    @(negedge clk);
    check("stall_misaligned", stall, 1);
    check("no_bus_req_misaligned", bus_req, 0);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    check("no_bus_req_exc", bus_req, 0);
    check("stall_exc_done", stall, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_uns = 1'b0; flush = 1'b0;
    mem_size = 2'b10; mem_addr = '0; mem_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_exc_valid", exc_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_exc_code", {27'h0, exc_code}, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_be", {28'h0, bus_be}, 0);
    check("rst_bus_addr", bus_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LW 0x100, minimum latency
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 32'h44332211, 4'b1111, 32'h0, 32'h11223344, 1'b0);
    // SB 0x203
    access(1'b1, 2'b00, 1'b0, 32'h203, 32'h000000A5, 1, 0, 32'h0, 4'b0001, 32'hA5A5A5A5, 32'h0, 1'b0);
    // LH / LHU 0x102 -> half 0x8001
    access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 2, 32'h00000180, 4'b0011, 32'h0, 32'hFFFF8001, 1'b0);
    access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 2, 1, 32'h00000180, 4'b0011, 32'h0, 32'h00008001, 1'b0);
    // LB 0x101 -> byte 0xF0 sign-extended; SW; SH offset 2
    access(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 0, 0, 32'h00F00000, 4'b0100, 32'h0, 32'hFFFFFFF0, 1'b0);
    access(1'b1, 2'b10, 1'b0, 32'h300, 32'h12345678, 0, 0, 32'h0, 4'b1111, 32'h78563412, 32'h0, 1'b0);
    access(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000BEEF, 0, 1, 32'h0, 4'b0011, 32'hEFBEEFBE, 32'h0, 1'b0);
    // LBU completing under a flush in DONE: no done pulse, result still captured
    access(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 0, 0, 32'h00F00000, 4'b0100, 32'h0, 32'h000000F0, 1'b1);

    misaligned(1'b0, 2'b10, 32'h102, 5'h04);
    misaligned(1'b1, 2'b01, 32'h101, 5'h05);

    // Flush in WAIT, response three cycles later is drained
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h104;
    @(posedge clk); #1;
    mem_req = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    check("flush_bus_req", bus_req, 1);
    @(posedge clk); #1;
    bus_gnt = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_stall_wait", stall, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      bus_rvalid = (i == 2);
      bus_rdata = 32'hDEADBEEF;
      @(negedge clk);
      check("drain_stall", stall, 1);
    end
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("drain_idle_stall", stall, 0);
    check("drain_rdata_kept", rdata, model_rdata);
    access(1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 0, 0, 32'h01020304, 4'b1111, 32'h0, 32'h04030201, 1'b0);

    // Async reset in REQ drops bus_req immediately; a stray response is ignored
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h10C;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    check("pre_reset_bus_req", bus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_bus_req", bus_req, 0);
    check("async_reset_stall", stall, 0);
    model_rdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("post_reset_idle_stall", stall, 0);
    check("post_reset_rdata", rdata, 0);

`ifdef MEM_ACCESS_BUS_TIMEOUT_EN
    begin
      exp_t e;
      e.is_exc = 1'b1; e.rdata = '0; e.code = 5'h07; e.badv = 32'h110;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h110;
    @(posedge clk); #1;
    mem_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("tmo_req_held", bus_req, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("tmo_bus_req_dropped", bus_req, 0);
    @(posedge clk); #1;
`else
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h110;
    @(posedge clk); #1;
    mem_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("no_tmo_stall", stall, 1);
      check("no_tmo_req", bus_req, 1);
    end
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle data-memory access stage for the MiniMIPS32 pipeline. It replaces the single-cycle, combinational memory stage.
- Drives a request/grant/response data bus with variable latency and stalls the pipeline while an access is outstanding.
- Detects misaligned addresses and performs load lane extraction with sign/zero extension.
- Sits between the execute/memory pipeline register and the write-back stage.

Parameters:
- ADDR_W, 32, data bus address width.
- BYTE_SWAP, 1: when 1, bus data lanes are byte-reversed, so bus bits [31:24] hold address offset 0. When 0, the bus is pass-through.
- TIMEOUT, 16: cycles allowed in REQ+WAIT before a bus error. Used only with BUS_TIMEOUT_EN.

Ports:
- cpu_clk_50M  in  1  clock, rising edge.
- cpu_rst_n  in  1  reset, asynchronous, active-low.
- mem_req_i  in  1  access request from pipeline; sampled only in IDLE.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word.
- mem_uns_i  in  1  load zero-extends (LBU/LHU).
- mem_addr_i  in  ADDR_W  effective address.
- mem_wdata_i  in  32  store data, right-aligned.
- flush_i  in  1  exception flush; abandons the access.
- stall_o  out  1  pipeline hold.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result, valid with done_o.
- exc_valid_o  out  1  one-cycle exception pulse.
- exc_code_o  out  5  0x04 AdEL, 0x05 AdES, 0x07 DBE.
- exc_badvaddr_o  out  ADDR_W  faulting address.
- bus_req_o  out  1  bus request.
- bus_gnt_i  in  1  bus accepts request this cycle.
- bus_addr_o  out  ADDR_W  word address: mem_addr with [1:0] forced to 00.
- bus_be_o  out  4  byte enables for stores, read enables for loads.
- bus_we_o  out  1  write strobe.
- bus_wdata_o  out  32  lane-replicated store data.
- bus_rvalid_i  in  1  response / write acknowledge.
- bus_rdata_i  in  32  read data.

Behaviour:
- Reset (cpu_rst_n low, asynchronous):
  - State IDLE.
  - All outputs 0, except stall_o, which is combinational and is 0 in IDLE when no request is pending.
  - A reset mid-access drops bus_req_o immediately; any later response is ignored.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- Enables, with k = addr[1:0]:
  - Byte: bus_be_o bit (3-k) set.
  - Half at offset 0: 1100; half at offset 2: 0011.
  - Word: 1111.
- Store data (BYTE_SWAP=1), with d = mem_wdata_i:
  - Word: {d[7:0],d[15:8],d[23:16],d[31:24]}.
  - Half: {d[7:0],d[15:8],d[7:0],d[15:8]}.
  - Byte: d[7:0] replicated 4x.
- Load data: r = byteswap(bus_rdata_i) when BYTE_SWAP=1, else r = bus_rdata_i.
  - Byte at offset k = r[8k+7:8k]; half at offset 0 = r[15:0], at offset 2 = r[31:16]; word = r.
  - Sign-extend unless mem_uns_i=1.
- IDLE:
  - mem_req_i & aligned & !flush_i: register addr/be/we/wdata, go to REQ. stall_o=1 combinationally in this same cycle.
  - mem_req_i & misaligned: no bus activity. Go to DONE with exception latched: code 0x05 for a store, 0x04 for a load; badvaddr = mem_addr_i. stall_o=1.
- REQ:
  - bus_req_o=1 with registered addr/be/we/wdata held stable until grant.
  - bus_gnt_i: go to WAIT, bus_req_o drops next cycle.
  - flush_i without grant: go to IDLE.
  - flush_i and bus_gnt_i in the same cycle: go to DRAIN.
- WAIT:
  - bus_rvalid_i: capture the extended result into rdata_o, go to DONE.
  - bus_rvalid_i is accepted even in the grant cycle+1.
  - flush_i: go to DRAIN. If rvalid and flush coincide, the response is discarded and the next state is IDLE.
- DRAIN: stall_o=1; wait for bus_rvalid_i, discard the data, go to IDLE.
- DONE:
  - done_o=1 (or exc_valid_o=1 for a faulting access); stall_o=0; go to IDLE.
  - A new mem_req_i is not sampled in DONE; it is sampled the following cycle.
  - flush_i in DONE suppresses done_o but not exc_valid_o.
- stall_o is 1 in REQ, WAIT and DRAIN, and in IDLE under a pending request; otherwise 0.
- Latency: minimum 4 cycles from request to done (IDLE→REQ→WAIT→DONE) with gnt and rvalid in consecutive cycles.
- rdata_o holds its value until the next load completes.
- Only one access is ever outstanding.

Optional Feature:
- Macro: MEM_ACCESS_BUS_TIMEOUT_EN.
- When defined:
  - A cycle counter (width ≥ clog2(TIMEOUT+1)) clears on entry to REQ and counts in REQ and WAIT.
  - On reaching TIMEOUT, go to DONE with exc_code_o=0x07 and badvaddr = the registered address. bus_req_o drops.
  - The bus is required to abandon the transaction; any later rvalid arriving in IDLE is ignored.
- When undefined: no counter, and the block waits indefinitely.

Test Plan:
- LW addr 0x100, bus gnt next cycle, rvalid with 0x44332211 (BYTE_SWAP=1) → bus_be_o=1111; done_o in cycle 4; rdata_o=0x11223344; stall_o high for exactly 3 cycles.
- SB addr 0x203, wdata 0x000000A5 → bus_be_o=0001, bus_we_o=1, bus_wdata_o=0xA5A5A5A5, bus_addr_o=0x200; done on rvalid.
- LH addr 0x102 with signed/unsigned variants, response yielding half 0x8001 → LH rdata_o=0xFFFF8001, LHU rdata_o=0x00008001.
- LW addr 0x102 → no bus_req_o; next cycle exc_valid_o=1, exc_code_o=0x04, exc_badvaddr_o=0x102. SH addr 0x101 → exc_code_o=0x05.
- flush_i asserted in WAIT, rvalid arrives 3 cycles later → no done_o; stall_o high until rvalid; state back to IDLE; next request proceeds normally. Async reset asserted in REQ → bus_req_o=0 immediately.
- With MEM_ACCESS_BUS_TIMEOUT_EN and TIMEOUT=16, grant never asserted → exc_code_o=0x07 after 16 cycles in REQ. Without the macro → stall_o stays high indefinitely.
